lr35902_oam_arbiter: RTL
========================

Name: lr35902_oam_arbiter

Overview:
Sole owner of the OAM SRAM port. Arbitrates between three masters: OAM DMA engine, PPU sprite fetch (modes 2/3) and CPU.
- Fixed priority: DMA > PPU > CPU.
- Inserts a bus-turnaround gap on every change of owner.
- Gives the CPU the DMG-accurate blocked-access view: reads return 0xFF, writes are lost.
- Provides a fixed 2-cycle read pipeline to every master.
Sits between the OAM DMA engine, the PPU and the CPU bus decoder at 0xFE00–0xFEFF.

Parameters:
TURNAROUND, 1, idle cycles inserted on each owner change (legal 1..3)
BLOCKED_DATA, 8'hFF, value returned to CPU reads issued while CPU is not owner

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low (0 = reset asserted)
cpu_adr  in  8  CPU OAM offset (0xFE00 base stripped)
cpu_din  in  8  CPU write data
cpu_read  in  1  CPU read strobe, one cycle per access
cpu_write  in  1  CPU write strobe, one cycle per access
cpu_dout  out  8  CPU read data
cpu_valid  out  1  cpu_dout valid pulse
cpu_blocked  out  1  high while CPU is not owner
ppu_req  in  1  PPU requests ownership (level)
ppu_adr  in  8  PPU read address
ppu_read  in  1  PPU read strobe
ppu_gnt  out  1  PPU owns OAM
ppu_dout  out  8  PPU read data
ppu_valid  out  1  ppu_dout valid pulse
dma_active  in  1  DMA requests ownership (level)
dma_adr  in  8  DMA OAM address
dma_din  in  8  DMA write data
dma_write  in  1  DMA write strobe
dma_gnt  out  1  DMA owns OAM
oam_adr  out  8  SRAM address
oam_dout  out  8  SRAM write data
oam_din  in  8  SRAM read data, valid the cycle after oam_rd
oam_rd  out  1  SRAM read enable
oam_wr  out  1  SRAM write enable

Behaviour:
States and reset:
- States: OWN_CPU, OWN_PPU, OWN_DMA, TURN, FLUSH.
- Reset (async) forces: OWN_CPU; turn counter 0; gnts 0; oam_rd/oam_wr 0; valids 0; douts 0xFF; pipeline and write buffer cleared.
- Reset mid-transfer discards any in-flight read. No valid pulse is produced for it.

Ownership:
- Each cycle, target = DMA if dma_active, else PPU if ppu_req, else CPU.
- Target differs from current owner → enter TURN. Hold TURN for TURNAROUND cycles with oam_rd = oam_wr = 0 and all gnts 0.
- At the end of TURN, re-evaluate target. The target may have changed during TURN; enter the new target with no second turnaround.
- Enter FLUSH instead of OWN_CPU when the target is CPU and the buffer is valid (see Optional Feature).
- Grants are registered: dma_gnt/ppu_gnt rise in the first cycle of the owner state and fall in the cycle TURN is entered.
- An owner losing its request while it owns the bus: its strobes that cycle are still served.

Access rules:
- Only the current owner drives oam_*. Strobes from non-owners are ignored, except CPU strobes, which are handled as blocked accesses.
- CPU with cpu_read and cpu_write both high: write wins.
- CPU address ≥ 0xA0: read returns 0x00; write is ignored; no oam_* activity, even as owner.

Read pipeline (uniform for every master):
- Strobe in cycle N → oam_rd in N → oam_din sampled at end of N+1 → dout/valid high in N+2 for exactly one cycle.
- Blocked CPU read: cpu_dout = BLOCKED_DATA, cpu_valid in N+2. Same latency.
- Reads keep the owner tag of the issue cycle, so data issued before an owner change still goes to the issuer.

Writes:
- Owner write drives oam_wr in the same cycle.
- Blocked CPU write is dropped, or buffered when the feature is on.

cpu_blocked = (state != OWN_CPU), combinational from the state register.

Optional Feature:
LR35902_OAM_WRBUF_EN
- Enabled: one-entry CPU write buffer {adr, data}. A blocked CPU write to an address < 0xA0 loads it; the last write wins.
- FLUSH (one cycle) performs oam_wr with the buffer contents and clears it, then goes to OWN_CPU.
- A CPU write during FLUSH reloads the buffer after the flush, and FLUSH repeats next cycle.
- A CPU read during FLUSH is blocked (returns BLOCKED_DATA).
- If the target leaves CPU during FLUSH: the flush completes, then TURN.
- Disabled: no buffer, FLUSH unreachable, blocked writes are lost (DMG behaviour).

Decomposition:
- Package lr35902_oam_pkg: state enum; owner-tag enum {CPU, PPU, DMA, NONE}; OAM_SIZE = 160; BLOCKED_DATA default.
- Sub-module lr35902_oam_rdpipe: 2-stage tag/data pipeline that steers oam_din or constant data to the tagged master's dout/valid.

Test Plan:
- Idle CPU: write 0x5A to 0x10, read 0x10 at N → oam_wr at write cycle; cpu_valid at N+2 with 0x5A.
- dma_active rises while CPU owner, TURNAROUND=1 → 1 TURN cycle with no oam activity, dma_gnt next cycle; CPU read of 0x00 → 0xFF at N+2.
- ppu_req and dma_active rise together → DMA owns; ppu_req held → after dma_active falls, one TURN then ppu_gnt.
- PPU read issued at the last owned cycle, then owner change → ppu_valid at N+2 with SRAM data; cpu_valid stays 0.
- WRBUF_EN: CPU writes 0x11 then 0x22 to 0x05 while PPU owns; ppu_req drops → TURN, FLUSH writes 0x22 to 0x05, then OWN_CPU. Without the macro, OAM[0x05] is unchanged.
- Reset asserted during DMA ownership with a read in flight → immediate OWN_CPU, no valid pulse; CPU read to 0xA5 after release → 0x00.

Source files
------------

// File: rtl/lr35902_oam_pkg.sv
// Shared types and constants for the OAM arbiter: ownership states, read-issuer
// tags, and the size of the populated OAM window.
package lr35902_oam_pkg;

  typedef enum logic [2:0] {
    OWN_CPU,
    OWN_PPU,
    OWN_DMA,
    TURN,
    FLUSH
  } oam_state_e;

  typedef enum logic [1:0] {
    TAG_CPU,
    TAG_PPU,
    TAG_DMA,
    TAG_NONE
  } oam_tag_e;

  localparam int unsigned OAM_SIZE         = 160;
  localparam logic [7:0]  BLOCKED_DATA_DEF = 8'hFF;

  // Offsets 0xA0..0xFF are unpopulated and never reach the SRAM.
  function automatic logic adr_in_oam(input logic [7:0] adr);
    return adr < 8'(OAM_SIZE);
  endfunction

endpackage

// File: rtl/lr35902_oam_rdpipe.sv
// Two-stage read return path: stage 1 holds the issuer tag (and any constant
// reply), stage 2 registers SRAM or constant data onto the tagged master's port.
module lr35902_oam_rdpipe
  import lr35902_oam_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  oam_tag_e   rd_tag,
  input  logic       const_vld,
  input  logic [7:0] const_data,
  input  logic [7:0] oam_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_valid,
  output logic [7:0] ppu_dout,
  output logic       ppu_valid
);

  oam_tag_e   tag_p1_q, tag_p1_d;
  logic       cvld_p1_q, cvld_p1_d;
  logic [7:0] cdat_p1_q, cdat_p1_d;
  logic [7:0] cpu_dout_q, cpu_dout_d;
  logic [7:0] ppu_dout_q, ppu_dout_d;
  logic       cpu_valid_q, cpu_valid_d;
  logic       ppu_valid_q, ppu_valid_d;

  always_comb begin
    tag_p1_d    = rd_tag;
    cvld_p1_d   = const_vld;
    cdat_p1_d   = const_data;
    cpu_valid_d = 1'b0;
    ppu_valid_d = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    ppu_dout_d  = ppu_dout_q;
    // Stage 2: SRAM data arrives one cycle after the strobe and is steered by tag.
    if (tag_p1_q == TAG_CPU) begin
      cpu_valid_d = 1'b1;
      cpu_dout_d  = oam_din;
    end else if (cvld_p1_q) begin
      cpu_valid_d = 1'b1;
      cpu_dout_d  = cdat_p1_q;
    end
    if (tag_p1_q == TAG_PPU) begin
      ppu_valid_d = 1'b1;
      ppu_dout_d  = oam_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_p1_q    <= TAG_NONE;
      cvld_p1_q   <= 1'b0;
      cdat_p1_q   <= 8'h00;
      cpu_dout_q  <= 8'hFF;
      ppu_dout_q  <= 8'hFF;
      cpu_valid_q <= 1'b0;
      ppu_valid_q <= 1'b0;
    end else begin
      tag_p1_q    <= tag_p1_d;
      cvld_p1_q   <= cvld_p1_d;
      cdat_p1_q   <= cdat_p1_d;
      cpu_dout_q  <= cpu_dout_d;
      ppu_dout_q  <= ppu_dout_d;
      cpu_valid_q <= cpu_valid_d;
      ppu_valid_q <= ppu_valid_d;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign cpu_valid = cpu_valid_q;
  assign ppu_dout  = ppu_dout_q;
  assign ppu_valid = ppu_valid_q;

endmodule

// File: rtl/lr35902_oam_arbiter.sv
// OAM SRAM owner: DMA > PPU > CPU with a turnaround gap on owner change.
// Define LR35902_OAM_WRBUF_EN to buffer one blocked CPU write and flush it on return.
module lr35902_oam_arbiter
  import lr35902_oam_pkg::*;
#(
  parameter int unsigned TURNAROUND   = 1,
  parameter logic [7:0]  BLOCKED_DATA = BLOCKED_DATA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_adr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_read,
  input  logic       cpu_write,
  output logic [7:0] cpu_dout,
  output logic       cpu_valid,
  output logic       cpu_blocked,
  input  logic       ppu_req,
  input  logic [7:0] ppu_adr,
  input  logic       ppu_read,
  output logic       ppu_gnt,
  output logic [7:0] ppu_dout,
  output logic       ppu_valid,
  input  logic       dma_active,
  input  logic [7:0] dma_adr,
  input  logic [7:0] dma_din,
  input  logic       dma_write,
  output logic       dma_gnt,
  output logic [7:0] oam_adr,
  output logic [7:0] oam_dout,
  input  logic [7:0] oam_din,
  output logic       oam_rd,
  output logic       oam_wr
);

  oam_state_e state_q, state_d, tgt_own;
  logic [1:0] turn_cnt_q, turn_cnt_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       ppu_gnt_q, ppu_gnt_d;

  logic       acc_rd, acc_wr, blk_wr, cvld;
  logic [7:0] acc_adr, acc_dat, cdat;
  oam_tag_e   rd_tag;

  logic       buf_vld_q, buf_vld_d;
  logic [7:0] buf_adr_q, buf_dat_q;

  assign tgt_own = dma_active ? OWN_DMA : (ppu_req ? OWN_PPU : OWN_CPU);

  always_comb begin
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    acc_adr = 8'h00;
    acc_dat = 8'h00;
    rd_tag  = TAG_NONE;
    cvld    = 1'b0;
    cdat    = BLOCKED_DATA;
    blk_wr  = 1'b0;
    case (state_q)
      OWN_CPU: begin
        if (cpu_write) begin
          if (adr_in_oam(cpu_adr)) begin
            acc_wr  = 1'b1;
            acc_adr = cpu_adr;
            acc_dat = cpu_din;
          end
        end else if (cpu_read) begin
          if (adr_in_oam(cpu_adr)) begin
            acc_rd  = 1'b1;
            acc_adr = cpu_adr;
            rd_tag  = TAG_CPU;
          end else begin
            cvld = 1'b1;
            cdat = 8'h00;
          end
        end
      end
      OWN_PPU: begin
        if (ppu_read) begin
          acc_rd  = 1'b1;
          acc_adr = ppu_adr;
          rd_tag  = TAG_PPU;
        end
      end
      OWN_DMA: begin
        if (dma_write) begin
          acc_wr  = 1'b1;
          acc_adr = dma_adr;
          acc_dat = dma_din;
        end
      end
      FLUSH: begin
        acc_wr  = buf_vld_q;
        acc_adr = buf_adr_q;
        acc_dat = buf_dat_q;
      end
      default: ;
    endcase
    // A non-owner CPU still gets a reply; the unpopulated window reads as zero.
    if (state_q != OWN_CPU) begin
      if (cpu_write) begin
        blk_wr = adr_in_oam(cpu_adr);
      end else if (cpu_read) begin
        cvld = 1'b1;
        cdat = adr_in_oam(cpu_adr) ? BLOCKED_DATA : 8'h00;
      end
    end
  end

`ifdef LR35902_OAM_WRBUF_EN
  logic [7:0] buf_adr_d, buf_dat_d;

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_adr_d = buf_adr_q;
    buf_dat_d = buf_dat_q;
    if (state_q == FLUSH) buf_vld_d = 1'b0;
    if (blk_wr) begin
      buf_vld_d = 1'b1;
      buf_adr_d = cpu_adr;
      buf_dat_d = cpu_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_vld_q <= 1'b0;
      buf_adr_q <= 8'h00;
      buf_dat_q <= 8'h00;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
    end
  end
`else
  assign buf_vld_q = 1'b0;
  assign buf_vld_d = 1'b0;
  assign buf_adr_q = 8'h00;
  assign buf_dat_q = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      OWN_CPU, OWN_PPU, OWN_DMA: begin
        if (tgt_own != state_q) begin
          state_d    = TURN;
          turn_cnt_d = 2'd0;
        end
      end
      TURN: begin
        // The target is sampled again on the last gap cycle; no second gap.
        if (turn_cnt_q == 2'(TURNAROUND - 1)) begin
          turn_cnt_d = 2'd0;
          state_d    = (tgt_own == OWN_CPU && buf_vld_d) ? FLUSH : tgt_own;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end
      FLUSH: begin
        if (tgt_own != OWN_CPU) begin
          state_d    = TURN;
          turn_cnt_d = 2'd0;
        end else if (blk_wr) begin
          state_d = FLUSH;
        end else begin
          state_d = OWN_CPU;
        end
      end
      default: state_d = OWN_CPU;
    endcase
    dma_gnt_d = (state_d == OWN_DMA);
    ppu_gnt_d = (state_d == OWN_PPU);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OWN_CPU;
      turn_cnt_q <= 2'd0;
      dma_gnt_q  <= 1'b0;
      ppu_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      dma_gnt_q  <= dma_gnt_d;
      ppu_gnt_q  <= ppu_gnt_d;
    end
  end

  lr35902_oam_rdpipe u_rdpipe (
    .clk        (clk),
    .reset      (reset),
    .rd_tag     (rd_tag),
    .const_vld  (cvld),
    .const_data (cdat),
    .oam_din    (oam_din),
    .cpu_dout   (cpu_dout),
    .cpu_valid  (cpu_valid),
    .ppu_dout   (ppu_dout),
    .ppu_valid  (ppu_valid)
  );

  assign oam_rd      = acc_rd & reset;
  assign oam_wr      = acc_wr & reset;
  assign oam_adr     = acc_adr;
  assign oam_dout    = acc_dat;
  assign cpu_blocked = (state_q != OWN_CPU);
  assign dma_gnt     = dma_gnt_q;
  assign ppu_gnt     = ppu_gnt_q;

endmodule
